psg_bus_decoder: RTL and testbench
==================================

# psg_bus_decoder

Host-side write decoder for the PSG. It accepts the byte-serial latch/data write protocol and holds the register file: three tone periods, one noise control word and four attenuations. It drives the tone generators, the `noise` block (`control`, `tone_freq`, `restart_noise`) and the attenuators directly. It is the stage immediately upstream of the noise generator.

## Interface
Parameters:
- `COUNTER_BITS`, default 10: width of the tone-period outputs.
  - Legal range is 4..10.
  - Each output carries the low `COUNTER_BITS` bits of its 10-bit stored period.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  reset; synchronous and active-high.
- `wr_en`  in  1  write strobe; one byte is accepted on each cycle it is high.
- `data`  in  8  write byte; sampled when `wr_en`=1.
- `tone0_period`, `tone1_period`, `tone2_period`  out  `COUNTER_BITS` each  tone periods for channels 0..2.
- `noise_control`  out  3  connects to `noise.control`: [2] FB (white noise), [1:0] NF.
- `noise_tone_freq`  out  `COUNTER_BITS`  connects to `noise.tone_freq`; always equal to `tone2_period`.
- `restart_noise`  out  1  one-cycle pulse on every noise-register write.
- `atten0`, `atten1`, `atten2`, `atten3`  out  4 each  attenuations for channels 0..2 and noise; 4'hF means silent.

## Operation
- Register index is `{chan[1:0], type}`, giving 8 registers. Type 0 is tone/noise; type 1 is attenuation. Channel 3 with type 0 is the noise register.
- Latch byte (`data[7]`=1):
  - `latched_idx` <= `data[6:4]`.
  - The selected register's low nibble <= `data[3:0]`.
  - For the noise register, only `data[2:0]` is stored and `restart_noise` fires.
- Data byte (`data[7]`=0), applied to `latched_idx`:
  - Tone register: `period[9:4]` <= `data[5:0]`. `period[3:0]` is unchanged.
  - Attenuation register: value <= `data[3:0]`.
  - Noise register: control <= `data[2:0]` and `restart_noise` fires.
  - `data[6]` is ignored in all cases.
- A data byte that arrives before any latch byte targets `latched_idx` reset value 0, which is tone 0.
- When `wr_en`=0, all state holds and `restart_noise`=0.

## Timing
- All outputs are registered. A write accepted on cycle N is visible on the outputs from cycle N+1.
- `restart_noise` is high during cycle N+1 only, the same cycle the new `noise_control` appears.
  - Back-to-back noise writes produce a pulse on each cycle.
- Reset values:
  - tone periods: 0
  - `noise_control`: 3'b000
  - attenuations: 4'hF
  - `latched_idx`: 0
  - `restart_noise`: 0
- Reset takes priority over `wr_en` in the same cycle. A write in the reset cycle is dropped.
- Reset between a latch byte and its data byte discards the latch. The following data byte goes to tone 0.
- Period 0 is passed through unchanged. How period 0 is interpreted is the tone generator's responsibility.
- Simultaneous events: the protocol accepts exactly one byte per cycle, so no write conflicts are possible.

## Configuration
- `PSG_NOISE_RESTART_EN`:
  - Defined: `restart_noise` pulses as described above.
  - Undefined: `restart_noise` is tied to 0, and noise writes update `noise_control` only. The LFSR then free-runs across control changes.

## Structure
- Shared package `psg_pkg` holds:
  - register index constants: `REG_TONE0`..`REG_TONE2`, `REG_NOISE`, `REG_ATT0`..`REG_ATT3`
  - `ATTEN_SILENT` = 4'hF
  - the latch-bit position constant
- Sub-module `psg_tone_reg`: one 10-bit tone period register with separate low-nibble and high-6 write enables, instantiated three times.
- All other logic is flat in `psg_bus_decoder`.

## Test plan
- Reset check: after reset, all attenuations read 4'hF, all periods read 0, `noise_control`=0, and `restart_noise` has never pulsed.
- Tone write: write 0x8E then 0x0F → `tone0_period` = 10'h0FE. After the first byte alone it reads 10'h00E.
- Noise write: write 0xE5 → `noise_control`=3'b101 at N+1, `restart_noise` high for exactly that cycle. A following data byte 0x02 → `noise_control`=3'b010 with a second pulse.
- Attenuation write: write 0xD3 → `atten2`=4'h3. A following data byte 0x0A → `atten2`=4'hA, with every tone period unchanged.
- Reset precedence: write 0xC1 with reset asserted in the same cycle → no change. After reset, data byte 0x3F → `tone0_period`[9:4]=6'h3F.
- Macro off: build without `PSG_NOISE_RESTART_EN` and write 0xE4 → `noise_control`=3'b100, `restart_noise` stays 0.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared definitions for the PSG host interface: register indices,
// the silent attenuation value and the latch-flag bit position.
package psg_pkg;

  // Register index is {chan[1:0], type}; type 1 selects attenuation.
  typedef enum logic [2:0] {
    REG_TONE0 = 3'd0,
    REG_ATT0  = 3'd1,
    REG_TONE1 = 3'd2,
    REG_ATT1  = 3'd3,
    REG_TONE2 = 3'd4,
    REG_ATT2  = 3'd5,
    REG_NOISE = 3'd6,
    REG_ATT3  = 3'd7
  } reg_idx_e;

  localparam logic [3:0]  ATTEN_SILENT = 4'hF;
  localparam int unsigned LATCH_BIT    = 7;

endpackage

// File: rtl/psg_tone_reg.sv
// One 10-bit tone period register. The low nibble is written by latch
// bytes and the upper six bits by data bytes.
module psg_tone_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       lo_we,
  input  logic       hi_we,
  input  logic [3:0] lo_data,
  input  logic [5:0] hi_data,
  output logic [9:0] period
);

  logic [9:0] period_d, period_q;

  // Merge the nibble and high-field writes into the next period value.
  always_comb begin
    period_d = period_q;
    if (lo_we) period_d[3:0] = lo_data;
    if (hi_we) period_d[9:4] = hi_data;
  end

  // Period register, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) period_q <= '0;
    else       period_q <= period_d;
  end

  assign period = period_q;

endmodule

// File: rtl/psg_bus_decoder.sv
// Byte-serial latch/data write decoder and register file for the PSG.
// Optional feature macro: PSG_NOISE_RESTART_EN (when defined, every
// noise-register write produces a one-cycle restart_noise pulse).
module psg_bus_decoder
  import psg_pkg::*;
#(
  parameter int COUNTER_BITS = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [7:0]              data,
  output logic [COUNTER_BITS-1:0] tone0_period,
  output logic [COUNTER_BITS-1:0] tone1_period,
  output logic [COUNTER_BITS-1:0] tone2_period,
  output logic [2:0]              noise_control,
  output logic [COUNTER_BITS-1:0] noise_tone_freq,
  output logic                    restart_noise,
  output logic [3:0]              atten0,
  output logic [3:0]              atten1,
  output logic [3:0]              atten2,
  output logic [3:0]              atten3
);

  reg_idx_e   latched_idx_d, latched_idx_q;
  reg_idx_e   idx;
  logic       is_latch;
  logic [2:0] tone_lo_we, tone_hi_we;
  logic       noise_we;
  logic [2:0] noise_d, noise_q;
  logic [3:0] atten_d [4];
  logic [3:0] atten_q [4];
  logic [9:0] period0, period1, period2;

  // Decode the incoming byte into per-register write enables and next values.
  always_comb begin
    is_latch      = data[LATCH_BIT];
    idx           = is_latch ? reg_idx_e'(data[6:4]) : latched_idx_q;
    latched_idx_d = (wr_en && is_latch) ? reg_idx_e'(data[6:4]) : latched_idx_q;
    tone_lo_we    = '0;
    tone_hi_we    = '0;
    noise_we      = 1'b0;
    atten_d       = atten_q;
    if (wr_en) begin
      unique case (idx)
        REG_TONE0: if (is_latch) tone_lo_we[0] = 1'b1; else tone_hi_we[0] = 1'b1;
        REG_TONE1: if (is_latch) tone_lo_we[1] = 1'b1; else tone_hi_we[1] = 1'b1;
        REG_TONE2: if (is_latch) tone_lo_we[2] = 1'b1; else tone_hi_we[2] = 1'b1;
        REG_NOISE: noise_we   = 1'b1;
        REG_ATT0:  atten_d[0] = data[3:0];
        REG_ATT1:  atten_d[1] = data[3:0];
        REG_ATT2:  atten_d[2] = data[3:0];
        REG_ATT3:  atten_d[3] = data[3:0];
      endcase
    end
    noise_d = noise_we ? data[2:0] : noise_q;
  end

  // Latched index, noise control and attenuation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      latched_idx_q <= REG_TONE0;
      noise_q       <= '0;
      atten_q       <= '{default: ATTEN_SILENT};
    end else begin
      latched_idx_q <= latched_idx_d;
      noise_q       <= noise_d;
      atten_q       <= atten_d;
    end
  end

  psg_tone_reg u_tone0 (
    .clk(clk), .reset(reset), .lo_we(tone_lo_we[0]), .hi_we(tone_hi_we[0]),
    .lo_data(data[3:0]), .hi_data(data[5:0]), .period(period0)
  );

  psg_tone_reg u_tone1 (
    .clk(clk), .reset(reset), .lo_we(tone_lo_we[1]), .hi_we(tone_hi_we[1]),
    .lo_data(data[3:0]), .hi_data(data[5:0]), .period(period1)
  );

  psg_tone_reg u_tone2 (
    .clk(clk), .reset(reset), .lo_we(tone_lo_we[2]), .hi_we(tone_hi_we[2]),
    .lo_data(data[3:0]), .hi_data(data[5:0]), .period(period2)
  );

`ifdef PSG_NOISE_RESTART_EN
  logic restart_d, restart_q;

  // Pulse lines up with the cycle the new noise control appears.
  always_comb begin
    restart_d = noise_we;
  end

  // Restart pulse register.
  always_ff @(posedge clk) begin
    if (reset) restart_q <= 1'b0;
    else       restart_q <= restart_d;
  end

  assign restart_noise = restart_q;
`else
  assign restart_noise = 1'b0;
`endif

  assign tone0_period    = period0[COUNTER_BITS-1:0];
  assign tone1_period    = period1[COUNTER_BITS-1:0];
  assign tone2_period    = period2[COUNTER_BITS-1:0];
  assign noise_tone_freq = period2[COUNTER_BITS-1:0];
  assign noise_control   = noise_q;
  assign atten0          = atten_q[0];
  assign atten1          = atten_q[1];
  assign atten2          = atten_q[2];
  assign atten3          = atten_q[3];

endmodule

// File: tb/tb_psg_bus_decoder.sv
// Self-checking bench for psg_bus_decoder: directed protocol cases plus
// randomized traffic against a register-file model kept in the bench.
module tb_psg_bus_decoder;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data  = '0;

  logic [9:0] tone0_period, tone1_period, tone2_period, noise_tone_freq;
  logic [2:0] noise_control;
  logic       restart_noise;
  logic [3:0] atten0, atten1, atten2, atten3;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

`ifdef PSG_NOISE_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  psg_bus_decoder #(.COUNTER_BITS(10)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data(data),
    .tone0_period(tone0_period), .tone1_period(tone1_period),
    .tone2_period(tone2_period), .noise_control(noise_control),
    .noise_tone_freq(noise_tone_freq), .restart_noise(restart_noise),
    .atten0(atten0), .atten1(atten1), .atten2(atten2), .atten3(atten3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: eight registers addressed by {chan, type}.
  logic [9:0] m_tone [3];
  logic [3:0] m_att  [4];
  logic [2:0] m_noise;
  logic [2:0] m_lidx;
  logic       m_restart;

  always @(posedge clk) begin
    logic [2:0]  idx;
    int unsigned chan;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
      for (int i = 0; i < 4; i++) m_att[i]  = 4'hF;
      m_noise   = 3'd0;
      m_lidx    = 3'd0;
      m_restart = 1'b0;
    end else begin
      m_restart = 1'b0;
      if (wr_en) begin
        idx = data[7] ? data[6:4] : m_lidx;
        if (data[7]) m_lidx = data[6:4];
        chan = int'(idx) / 2;
        if (idx % 2 == 1)      m_att[chan] = data[3:0];
        else if (chan == 3) begin
          m_noise   = data[2:0];
          m_restart = RESTART_EN;
        end
        else if (data[7])      m_tone[chan] = (m_tone[chan] & 10'h3F0) | 10'(data[3:0]);
        else                   m_tone[chan] = (m_tone[chan] & 10'h00F) | (10'(data[5:0]) << 4);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tone0", 16'(tone0_period), 16'(m_tone[0]));
      chk("tone1", 16'(tone1_period), 16'(m_tone[1]));
      chk("tone2", 16'(tone2_period), 16'(m_tone[2]));
      chk("noise_freq", 16'(noise_tone_freq), 16'(m_tone[2]));
      chk("noise_ctl", 16'(noise_control), 16'(m_noise));
      chk("restart", 16'(restart_noise), 16'(m_restart));
      chk("att0", 16'(atten0), 16'(m_att[0]));
      chk("att1", 16'(atten1), 16'(m_att[1]));
      chk("att2", 16'(atten2), 16'(m_att[2]));
      chk("att3", 16'(atten3), 16'(m_att[3]));
    end
  end

  task automatic wr(input logic [7:0] b);
    @(posedge clk); #1;
    wr_en = 1'b1;
    data  = b;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    wr_en = 1'b0;
    reset = 1'b0;
    data  = $urandom;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    chk("rst_att0", 16'(atten0), 16'hF);
    chk("rst_att3", 16'(atten3), 16'hF);
    chk("rst_tone0", 16'(tone0_period), 16'h0);
    chk("rst_noise", 16'(noise_control), 16'h0);
    chk("rst_restart", 16'(restart_noise), 16'h0);

    wr(8'h8E); idle(); @(negedge clk);
    chk("tone_latch", 16'(tone0_period), 16'h00E);
    wr(8'h0F); idle(); @(negedge clk);
    chk("tone_data", 16'(tone0_period), 16'h0FE);

    wr(8'hE5); idle(); @(negedge clk);
    chk("noise_latch", 16'(noise_control), 16'h5);
    chk("noise_pulse1", 16'(restart_noise), 16'(RESTART_EN));
    @(negedge clk);
    chk("noise_pulse_end", 16'(restart_noise), 16'h0);
    wr(8'h02); idle(); @(negedge clk);
    chk("noise_data", 16'(noise_control), 16'h2);
    chk("noise_pulse2", 16'(restart_noise), 16'(RESTART_EN));

    wr(8'hE1); wr(8'hE6); idle(); @(negedge clk);
    chk("noise_b2b", 16'(noise_control), 16'h6);
    chk("noise_b2b_pulse", 16'(restart_noise), 16'(RESTART_EN));

    wr(8'hD3); idle(); @(negedge clk);
    chk("att_latch", 16'(atten2), 16'h3);
    wr(8'h0A); idle(); @(negedge clk);
    chk("att_data", 16'(atten2), 16'hA);
    chk("att_tone0_keep", 16'(tone0_period), 16'h0FE);

    wr(8'hC7); idle(); @(negedge clk);
    chk("tone2_latch", 16'(tone2_period), 16'h007);
    @(posedge clk); #1;
    reset = 1'b1; wr_en = 1'b1; data = 8'hC1;
    idle(); @(negedge clk);
    chk("rst_prec_tone2", 16'(tone2_period), 16'h0);
    chk("rst_prec_att2", 16'(atten2), 16'hF);

    wr(8'hA5); idle();
    @(posedge clk); #1 reset = 1'b1;
    idle();
    wr(8'h3F); idle(); @(negedge clk);
    chk("latch_drop_tone0", 16'(tone0_period), 16'h3F0);
    chk("latch_drop_tone1", 16'(tone1_period), 16'h0);

    wr(8'hE4); idle(); @(negedge clk);
    chk("noise_e4", 16'(noise_control), 16'h4);
    chk("noise_e4_pulse", 16'(restart_noise), 16'(RESTART_EN));

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(63) == 0);
      wr_en = ($urandom_range(3) != 0);
      data  = $urandom;
      if ($urandom_range(3) == 0) data[7:4] = 4'hE;
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
